// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back port: queue entry layout and default depth.
package wb_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(input logic [4:0] rw, input logic [31:0] data);
        wb_entry_t e;
        e.rw   = rw;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_write_port_if.sv
// Bus bundle for wb_write_port: two result sources, register-file write port and forwarding lookup.
interface wb_write_port_if import wb_pkg::*; #(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rw;
    logic [31:0]   mem_di;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rw;
    logic [31:0]   alu_di;
    logic          reg_wr;
    logic [4:0]    rw;
    logic [31:0]   di;
    logic [4:0]    ra;
    logic [4:0]    rb;
    logic          fwd_a_hit;
    logic [31:0]   fwd_a;
    logic          fwd_b_hit;
    logic [31:0]   fwd_b;
    logic [CW-1:0] count;

    modport master (
        output mem_valid, mem_rw, mem_di, alu_valid, alu_rw, alu_di, ra, rb,
        input  mem_ready, alu_ready, reg_wr, rw, di,
               fwd_a_hit, fwd_a, fwd_b_hit, fwd_b, count
    );

    modport slave (
        input  mem_valid, mem_rw, mem_di, alu_valid, alu_rw, alu_di, ra, rb,
        output mem_ready, alu_ready, reg_wr, rw, di,
               fwd_a_hit, fwd_a, fwd_b_hit, fwd_b, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular entry queue with two ordered write ports (wr0 older than wr1) and one read port.
module wb_fifo import wb_pkg::*; #(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  wb_entry_t     wr0_data,
    input  logic          wr1_en,
    input  wb_entry_t     wr1_data,
    input  logic          rd_en,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic [AW-1:0] rd_ptr,
    output wb_entry_t     slots [DEPTH]
);

    logic [AW-1:0] wr_ptr;

    // wr1 lands behind wr0 when both fire so queue order matches arrival order
    always_ff @(posedge clk) begin
        if (wr0_en) slots[wr_ptr] <= wr0_data;
        if (wr1_en) slots[wr0_en ? wr_ptr + AW'(1) : wr_ptr] <= wr1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/wb_write_port.sv
// Merges load and ALU results into an ordered register-file write stream.
// Optional operand forwarding from pending entries: define WB_FORWARD_EN.
module wb_write_port import wb_pkg::*; #(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_port_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    wb_entry_t     slots [DEPTH];
    wb_entry_t     head;
    logic          mem_ready, alu_ready, mem_push, alu_push, pop;
    logic          reg_wr;
    logic [4:0]    rw;
    logic [31:0]   di;
    logic [32:0]   fa, fb;

    // Credit comes from start-of-cycle occupancy only; the Mem slot is reserved first
    always_comb begin
        mem_ready = !rst && (count <= CW'(DEPTH - 1));
        alu_ready = !rst && ((count <= CW'(DEPTH - 2)) ||
                             ((count == CW'(DEPTH - 1)) && !bus.mem_valid));
    end

    assign mem_push = bus.mem_valid && mem_ready && (bus.mem_rw != REG_ZERO);
    assign alu_push = bus.alu_valid && alu_ready && (bus.alu_rw != REG_ZERO);
    assign pop      = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (mem_push),
        .wr0_data (make_entry(bus.mem_rw, bus.mem_di)),
        .wr1_en   (alu_push),
        .wr1_data (make_entry(bus.alu_rw, bus.alu_di)),
        .rd_en    (pop),
        .head     (head),
        .count    (count),
        .rd_ptr   (rd_ptr),
        .slots    (slots)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr <= 1'b0;
            rw     <= '0;
            di     <= '0;
        end else begin
            reg_wr <= pop;
            if (pop) begin
                rw <= head.rw;
                di <= head.data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match wins; the output register is oldest of all
    function automatic logic [32:0] lookup(input logic [4:0] r);
        logic [32:0] res;
        wb_entry_t   e;
        res = '0;
        if (r != REG_ZERO) begin
            if (reg_wr && (rw == r)) res = {1'b1, di};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e = slots[rd_ptr + AW'(i)];
                if ((CW'(i) < count) && (e.rw == r)) res = {1'b1, e.data};
            end
        end
        return res;
    endfunction

    always_comb begin
        fa = lookup(bus.ra);
        fb = lookup(bus.rb);
        if (rst) begin
            fa = '0;
            fb = '0;
        end
    end
`else
    logic fwd_unused;
    always_comb begin
        fa = '0;
        fb = '0;
        fwd_unused = ^{rd_ptr, bus.ra, bus.rb};
        for (int unsigned i = 0; i < DEPTH; i++) fwd_unused = fwd_unused ^ (^slots[i]);
    end
`endif

    assign bus.mem_ready = mem_ready;
    assign bus.alu_ready = alu_ready;
    assign bus.reg_wr    = reg_wr;
    assign bus.rw        = rw;
    assign bus.di        = di;
    assign bus.count     = count;
    assign bus.fwd_a_hit = fa[32];
    assign bus.fwd_a     = fa[31:0];
    assign bus.fwd_b_hit = fb[32];
    assign bus.fwd_b     = fb[31:0];

endmodule
